// File: rtl/key_onehot_capture.sv
// rtl/key_onehot_capture.sv - key synchroniser, debouncer and single-press one-hot capture
// Feeds the 4-to-2 encoder A input with 0000 or exactly one set bit.
module key_onehot_capture #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic [3:0] onehot,
    output logic       valid,
    output logic       multi,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       sync1;
    logic [3:0]       ks;
    logic [3:0]       stable;
    logic [CNT_W-1:0] cnt [4];

    state_t state;
    state_t state_n;
    logic   load_n;
    logic   valid_n;
    logic   multi_n;
    logic   single;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 4'b0000;
            ks     <= 4'b0000;
            stable <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= key;
            ks    <= sync1;
            // The terminal compare fires before the counter could ever wrap.
            for (int i = 0; i < 4; i++) begin
                if (ks[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= ks[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign single = (stable != 4'b0000) && ((stable & (stable - 4'b0001)) == 4'b0000);

    always_comb begin
        state_n = state;
        load_n  = 1'b0;
        valid_n = 1'b0;
        multi_n = 1'b0;
        case (state)
            IDLE: begin
                if (stable != 4'b0000) begin
                    state_n = HELD;
                    if (single) begin
                        load_n  = 1'b1;
                        valid_n = 1'b1;
                    end else begin
                        multi_n = 1'b1;
                    end
                end
            end
            HELD: begin
                if (stable == 4'b0000) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decision so they align with the state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            onehot <= 4'b0000;
            valid  <= 1'b0;
            multi  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state <= state_n;
            valid <= valid_n;
            multi <= multi_n;
            busy  <= (state_n == HELD);
            if (load_n) begin
                onehot <= stable;
            end
        end
    end

endmodule

// File: tb/tb_key_onehot_capture.sv
// tb/tb_key_onehot_capture.sv - scoreboard bench for key_onehot_capture
// Expected strobes are queued with their cycle when stimulus is driven.
module tb_key_onehot_capture;

    logic       clk;
    logic       rst;
    logic [3:0] key;
    logic [3:0] onehot;
    logic       valid;
    logic       multi;
    logic       busy;

    int vectors;
    int miscompares;
    int cyc;

    typedef struct {
        logic       is_multi;
        logic [3:0] oh;
        int         at;
    } exp_t;

    exp_t q[$];

    key_onehot_capture #(.DB_CYCLES(4), .CNT_W(20)) dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .onehot (onehot),
        .valid  (valid),
        .multi  (multi),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] enc(input logic [3:0] a);
        case (a)
            4'b0001: enc = 2'b00;
            4'b0010: enc = 2'b01;
            4'b0100: enc = 2'b10;
            4'b1000: enc = 2'b11;
            default: enc = 2'b00;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic is_multi, input logic [3:0] oh, input int at);
        exp_t e;
        e.is_multi = is_multi;
        e.oh       = oh;
        e.at       = at;
        q.push_back(e);
    endtask

    // Strobe monitor: pops the scoreboard on each valid/multi and flags missed strobes.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && cyc > q[0].at) begin
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missed_strobe: got none by cycle %0d, want multi=%b onehot=%b at cycle %0d",
                     cyc, e.is_multi, e.oh, e.at);
        end
        if (!rst && (valid === 1'b1 || multi === 1'b1)) begin
            if (valid === 1'b1 && multi === 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL valid_multi_exclusive: got valid=1 multi=1 at cycle %0d, want not both", cyc);
            end
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got valid=%b multi=%b onehot=%b at cycle %0d, want none",
                         valid, multi, onehot, cyc);
            end else begin
                e = q.pop_front();
                vectors++;
                if (multi !== e.is_multi || onehot !== e.oh || cyc !== e.at) begin
                    miscompares++;
                    $display("FAIL strobe: got multi=%b onehot=%b cycle=%0d, want multi=%b onehot=%b cycle=%0d",
                             multi, onehot, cyc, e.is_multi, e.oh, e.at);
                end
            end
        end
    end

    task automatic test_reset();
        int c;
        rst = 1'b1;
        key = 4'b1111;
        step(2);
        vectors++;
        if (onehot !== 4'b0000) begin miscompares++; $display("FAIL reset_onehot: got %b want 0000", onehot); end
        vectors++;
        if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
        vectors++;
        if (multi !== 1'b0) begin miscompares++; $display("FAIL reset_multi: got %b want 0", multi); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        c = cyc;
        expect_pulse(1'b1, 4'b0000, c + 7);
        step(6);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_early_busy: got %b want 0", busy); end
        step(2);
        vectors++;
        if (busy !== 1'b1 || onehot !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_held_keys: got busy=%b onehot=%b want busy=1 onehot=0000", busy, onehot);
        end
        key = 4'b0000;
        step(8);
    endtask

    task automatic test_single();
        int c;
        key = 4'b0010;
        c = cyc;
        expect_pulse(1'b0, 4'b0010, c + 7);
        step(20);
        vectors++;
        if (onehot !== 4'b0010 || enc(onehot) !== 2'b01) begin
            miscompares++;
            $display("FAIL single_onehot: got %b (Y=%b) want 0010 (Y=01)", onehot, enc(onehot));
        end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
        key = 4'b0000;
        step(6);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single_release_early: got busy=%b want 1", busy); end
        step(1);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL single_release: got busy=%b want 0", busy); end
        vectors++;
        if (onehot !== 4'b0010) begin miscompares++; $display("FAIL single_hold: got %b want 0010", onehot); end
        step(2);
    endtask

    task automatic test_bounce();
        int busy_seen;
        busy_seen = 0;
        for (int s = 0; s < 6; s++) begin
            key = (s % 2 == 0) ? 4'b0100 : 4'b0000;
            repeat (2) begin
                step(1);
                if (busy !== 1'b0) busy_seen++;
            end
        end
        key = 4'b0000;
        step(8);
        key = 4'b1000;
        step(3);
        key = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (busy !== 1'b0) busy_seen++;
        end
        vectors++;
        if (busy_seen != 0) begin miscompares++; $display("FAIL bounce_busy: got %0d busy cycles want 0", busy_seen); end
        vectors++;
        if (onehot !== 4'b0010) begin miscompares++; $display("FAIL bounce_onehot: got %b want 0010", onehot); end
    endtask

    task automatic test_simultaneous();
        int c;
        key = 4'b0101;
        c = cyc;
        expect_pulse(1'b1, 4'b0010, c + 7);
        step(10);
        vectors++;
        if (busy !== 1'b1 || onehot !== 4'b0010) begin
            miscompares++;
            $display("FAIL simul_state: got busy=%b onehot=%b want busy=1 onehot=0010", busy, onehot);
        end
        key = 4'b0000;
        step(8);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL simul_release: got busy=%b want 0", busy); end
    endtask

    task automatic test_staggered();
        int c;
        key = 4'b1000;
        c = cyc;
        expect_pulse(1'b0, 4'b1000, c + 7);
        step(10);
        key = 4'b1001;
        step(10);
        vectors++;
        if (onehot !== 4'b1000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stagger_first: got onehot=%b busy=%b want onehot=1000 busy=1", onehot, busy);
        end
        key = 4'b0000;
        step(8);
        key = 4'b0001;
        c = cyc;
        expect_pulse(1'b0, 4'b0001, c + 7);
        step(10);
        vectors++;
        if (onehot !== 4'b0001 || enc(onehot) !== 2'b00) begin
            miscompares++;
            $display("FAIL stagger_second: got onehot=%b (Y=%b) want 0001 (Y=00)", onehot, enc(onehot));
        end
        key = 4'b0000;
        step(8);
    endtask

    task automatic test_reset_mid();
        int c;
        key = 4'b0100;
        c = cyc;
        expect_pulse(1'b0, 4'b0100, c + 7);
        step(10);
        vectors++;
        if (onehot !== 4'b0100 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pre: got onehot=%b busy=%b want onehot=0100 busy=1", onehot, busy);
        end
        rst = 1'b1;
        step(1);
        vectors++;
        if (onehot !== 4'b0000 || valid !== 1'b0 || multi !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_clear: got onehot=%b valid=%b multi=%b busy=%b want all 0",
                     onehot, valid, multi, busy);
        end
        rst = 1'b0;
        c = cyc;
        expect_pulse(1'b0, 4'b0100, c + 7);
        step(6);
        vectors++;
        if (onehot !== 4'b0000) begin miscompares++; $display("FAIL midrst_early: got %b want 0000", onehot); end
        step(4);
        vectors++;
        if (onehot !== 4'b0100 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_reaccept: got onehot=%b busy=%b want onehot=0100 busy=1", onehot, busy);
        end
        key = 4'b0000;
        step(8);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        key         = 4'b0000;
        step(1);
        test_reset();
        test_single();
        test_bounce();
        test_simultaneous();
        test_staggered();
        test_reset_mid();
        step(4);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending strobes want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
